// File: rtl/fetch_queue.sv
// Fetch buffer between the PC stage and decode: one request stage plus a DEPTH-entry FIFO.
// Optional macro FETCH_BYPASS_EN forwards the ROM word straight to decode when the queue is empty.
module fetch_queue #(
  parameter int ADDR_W = 6,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              resetIn,
  input  logic              pcResetIn,
  input  logic [ADDR_W-1:0] pcAddrIn,
  input  logic [INST_W-1:0] romDataIn,
  input  logic              flushIn,
  input  logic              readyIn,
  output logic              pcEnableOut,
  output logic              validOut,
  output logic [INST_W-1:0] instOut,
  output logic [ADDR_W-1:0] instAddrOut
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  logic credit;
  logic issue;
  logic bypass;
  logic bypass_take;
  logic push;
  logic pop;

  // Credit counts the in-flight request but not a same-cycle pop, so a push never finds the queue full.
  always_comb begin
    credit      = (count + (PTR_W+1)'(req_valid)) < (PTR_W+1)'(DEPTH);
    pcEnableOut = !resetIn & (flushIn | (!pcResetIn & credit));
    issue       = pcEnableOut & !pcResetIn & !flushIn;
  end

  always_comb begin
`ifdef FETCH_BYPASS_EN
    bypass = (count == '0) & req_valid & !flushIn;
`else
    bypass = 1'b0;
`endif
    bypass_take = bypass & readyIn;
    validOut    = (count != '0) | bypass;
    instOut     = bypass ? romDataIn : inst_mem[rd_ptr];
    instAddrOut = bypass ? req_addr  : addr_mem[rd_ptr];
    push        = req_valid & !flushIn & !resetIn & !bypass_take;
    pop         = (count != '0) & readyIn;
  end

  always_ff @(posedge clk) begin
    if (resetIn || flushIn) begin
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      req_valid <= 1'b0;
    end else begin
      req_valid <= issue;
      if (issue) req_addr <= pcAddrIn;
      if (push)  wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= req_addr;
      inst_mem[wr_ptr] <= romDataIn;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: PC/ROM environment, queue-of-addresses reference model, directed scenarios.
// Build with FETCH_BYPASS_EN defined to exercise the bypass variant.
module tb_fetch_queue;
  localparam int ADDR_W = 6;
  localparam int INST_W = 32;
  localparam int DEPTH  = 4;
`ifdef FETCH_BYPASS_EN
  localparam int FIRST_LAT = 3;
  localparam int STEADY_COUNT = 0;
`else
  localparam int FIRST_LAT = 4;
  localparam int STEADY_COUNT = 1;
`endif

  logic              clk = 1'b0;
  logic              resetIn = 1'b1;
  logic              pcResetIn = 1'b1;
  logic [ADDR_W-1:0] pcAddrIn = '0;
  logic [INST_W-1:0] romDataIn = '0;
  logic              flushIn = 1'b0;
  logic              readyIn = 1'b1;
  logic [ADDR_W-1:0] jump_target = '0;
  logic              pcEnableOut;
  logic              validOut;
  logic [INST_W-1:0] instOut;
  logic [ADDR_W-1:0] instAddrOut;

  int checks = 0;
  int failures = 0;

  fetch_queue #(.ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .resetIn(resetIn), .pcResetIn(pcResetIn), .pcAddrIn(pcAddrIn),
    .romDataIn(romDataIn), .flushIn(flushIn), .readyIn(readyIn),
    .pcEnableOut(pcEnableOut), .validOut(validOut), .instOut(instOut),
    .instAddrOut(instAddrOut)
  );

  always #5 clk = ~clk;

  function automatic logic [INST_W-1:0] rom_word(logic [ADDR_W-1:0] a);
    return {16'hC0DE, 4'h5, a, ~a};
  endfunction

  // PC stage and synchronous ROM
  always @(posedge clk) begin
    pcResetIn <= resetIn;
    romDataIn <= rom_word(pcAddrIn);
    if (resetIn)          pcAddrIn <= '0;
    else if (flushIn)     pcAddrIn <= jump_target;
    else if (pcEnableOut) pcAddrIn <= pcAddrIn + 6'd2;
  end

  // Reference model: ordered list of queued addresses plus one in-flight request.
  logic [ADDR_W-1:0] mq[$];
  bit                m_inflight = 0;
  logic [ADDR_W-1:0] m_inflight_addr = '0;
  bit                m_init = 0;
  logic [ADDR_W-1:0] dlog[$];
  int                since_rst = 0;
  int                first_valid = 0;

  function automatic bit exp_en();
    return !resetIn && (flushIn || (!pcResetIn && (mq.size() + int'(m_inflight)) < DEPTH));
  endfunction

  function automatic bit exp_bypass();
`ifdef FETCH_BYPASS_EN
    return mq.size() == 0 && m_inflight && !flushIn;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit exp_valid();
    return mq.size() != 0 || exp_bypass();
  endfunction

  function automatic logic [ADDR_W-1:0] exp_head();
    return (mq.size() != 0) ? mq[0] : m_inflight_addr;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_log(string name, int idx, int exp);
    if (idx < dlog.size()) chk(name, 64'(dlog[idx]), 64'(exp));
    else begin
      checks++;
      failures++;
      $display("FAIL %s actual=missing required=%0h", name, exp);
    end
  endtask

  always @(posedge clk) begin
    bit en, byp, val, taken;
    en  = exp_en();
    byp = exp_bypass();
    val = exp_valid();
    taken = byp && readyIn;
    if (resetIn) begin
      mq.delete();
      m_inflight = 0;
      m_init = 1;
    end else if (m_init) begin
      if (flushIn) begin
        mq.delete();
        m_inflight = 0;
      end else begin
        if (val && readyIn && mq.size() != 0) void'(mq.pop_front());
        if (m_inflight && !taken) begin
          checks++;
          assert (mq.size() < DEPTH) else begin
            failures++;
            $display("FAIL overflow actual=%0d required=<%0d", mq.size(), DEPTH);
          end
          mq.push_back(m_inflight_addr);
        end
        m_inflight = en && !pcResetIn;
        m_inflight_addr = pcAddrIn;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (m_init) begin
      bit ev;
      ev = exp_valid();
      chk("pcEnableOut", 64'(pcEnableOut), 64'(exp_en()));
      chk("validOut", 64'(validOut), 64'(ev));
      if (ev && validOut) begin
        chk("instAddrOut", 64'(instAddrOut), 64'(exp_head()));
        chk("instOut", 64'(instOut), 64'(rom_word(exp_head())));
      end
      if (validOut && readyIn) dlog.push_back(instAddrOut);
      if (resetIn) begin
        since_rst = 0;
        first_valid = 0;
      end else begin
        since_rst++;
        if (validOut && first_valid == 0) first_valid = since_rst;
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetIn = 1'b1;
    step(2);
    resetIn = 1'b0;
    dlog.delete();
  endtask

  initial begin
    // Streaming from reset with decode always ready
    readyIn = 1'b1;
    do_reset();
    #1 chk("en_during_pcreset", 64'(pcEnableOut), 64'd0);
    step(20);
    chk("first_valid_cycle", 64'(first_valid), 64'(FIRST_LAT));
    chk("steady_count", 64'(dut.count), 64'(STEADY_COUNT));
    for (int i = 0; i < 8; i++) chk_log("stream_addr", i, 2 * i);

    // Fill with decode stalled, then drain
    readyIn = 1'b0;
    do_reset();
    step(10);
    #1 chk("full_en", 64'(pcEnableOut), 64'd0);
    chk("full_pc_hold", 64'(pcAddrIn), 64'h08);
    chk("full_head", 64'(instAddrOut), 64'h00);
    readyIn = 1'b1;
    step(12);
    for (int i = 0; i < 6; i++) chk_log("drain_addr", i, 2 * i);

    // Flush with 0x10, 0x12 queued and 0x14 in flight
    readyIn = 1'b0;
    do_reset();
    step(3);
    jump_target = 6'h10;
    flushIn = 1'b1;
    step(1);
    flushIn = 1'b0;
    step(3);
    chk("preflush_head", 64'(instAddrOut), 64'h10);
    jump_target = 6'h20;
    flushIn = 1'b1;
    #1 chk("flush_en", 64'(pcEnableOut), 64'd1);
    step(1);
    flushIn = 1'b0;
    #1 chk("postflush_valid", 64'(validOut), 64'd0);
    readyIn = 1'b1;
    dlog.delete();
    step(8);
    chk_log("jump_addr0", 0, 'h20);
    chk_log("jump_addr1", 1, 'h22);

    // Reset while three entries are queued
    readyIn = 1'b0;
    do_reset();
    for (int i = 0; i < 20 && mq.size() != 3; i++) step(1);
    chk("model_three_queued", 64'(mq.size()), 64'd3);
    resetIn = 1'b1;
    step(1);
    resetIn = 1'b0;
    #1 chk("post_reset_valid", 64'(validOut), 64'd0);
    readyIn = 1'b1;
    dlog.delete();
    step(15);
    chk_log("restart_addr0", 0, 'h00);
    chk_log("restart_addr1", 1, 'h02);

    // Full queue with decode toggling
    readyIn = 1'b0;
    do_reset();
    step(8);
    dlog.delete();
    for (int i = 0; i < 16; i++) begin
      readyIn = (i % 2 == 0);
      step(1);
    end
    readyIn = 1'b1;
    step(10);
    for (int i = 0; i < 10; i++) chk_log("toggle_addr", i, 2 * i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

endmodule
